// File: rtl/sram1w1r_ctrl.sv
// ---------------------------------------------------------------------------
// sram1w1r_ctrl
//   Controller for one 1-write/1-read SRAM. After reset or flush it sweeps
//   CLEAR_VALUE into every set. It then arbitrates the single read port
//   round-robin among NUM_REQ requesters and passes one writer straight
//   through to the write port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | sweep CLEAR_VALUE into sets 0..SETS_NUM-1, clients held off
//   RUN   | SRAM usable: RR read arbitration, write pass-through
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   flush_req                         pulse, re-runs the clear sweep from RUN
//   init_done                         1 while in RUN
//   rd_req_valid/addr/ready           per-requester read request, one-hot grant
//   rd_resp_valid/id/data             read response, one cycle after the grant
//   wr_valid/addr/data/ready          write client
//   sram_read_*, sram_write_*         direct connection to the SRAM macro
// ---------------------------------------------------------------------------
module sram1w1r_ctrl #(
   parameter int                    SETS_NUM    = 16,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REQ     = 4,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
   localparam int                   AW          = $clog2(SETS_NUM),
   localparam int                   IW          = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush_req,
   output logic                         init_done,
   input  logic [NUM_REQ-1:0]           rd_req_valid,
   input  logic [NUM_REQ-1:0][AW-1:0]   rd_req_addr,
   output logic [NUM_REQ-1:0]           rd_req_ready,
   output logic                         rd_resp_valid,
   output logic [IW-1:0]                rd_resp_id,
   output logic [DATA_WIDTH-1:0]        rd_resp_data,
   input  logic                         wr_valid,
   input  logic [AW-1:0]                wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         wr_ready,
   output logic                         sram_read_en,
   output logic [AW-1:0]                sram_read_addr,
   input  logic [DATA_WIDTH-1:0]        sram_read_data,
   output logic                         sram_write_en,
   output logic [AW-1:0]                sram_write_addr,
   output logic [DATA_WIDTH-1:0]        sram_write_data
);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_clr_cnt;
   logic [IW-1:0]   r_rr_ptr;
   logic            r_init_done;
   logic            r_resp_valid;
   logic [IW-1:0]   r_resp_id;

   logic            w_run;
   logic            w_gnt_found;
   logic [IW-1:0]   w_gnt_idx;
   logic            w_grant;
   logic [IW-1:0]   w_rr_next;

   assign w_run = (r_state == ST_RUN);

   // Search upward from the round-robin pointer, wrapping at NUM_REQ.
   always_comb begin : p_arb
      int v;
      v           = 0;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v = int'(r_rr_ptr) + k;
         if (v >= NUM_REQ) v = v - NUM_REQ;
         if (!w_gnt_found && rd_req_valid[IW'(v)]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = IW'(v);
         end
      end
   end

   assign w_grant   = w_run && w_gnt_found;
   assign w_rr_next = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   assign rd_req_ready   = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;
   assign sram_read_en   = w_grant;
   assign sram_read_addr = rd_req_addr[w_gnt_idx];

   assign wr_ready        = w_run;
   assign sram_write_en   = w_run ? wr_valid : 1'b1;
   assign sram_write_addr = w_run ? wr_addr  : r_clr_cnt;
   assign sram_write_data = w_run ? wr_data  : CLEAR_VALUE;

   assign init_done     = r_init_done;
   assign rd_resp_valid = r_resp_valid;
   assign rd_resp_id    = r_resp_id;
   assign rd_resp_data  = sram_read_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_CLEAR;
         r_clr_cnt    <= '0;
         r_rr_ptr     <= '0;
         r_init_done  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
      end else begin
         r_resp_valid <= w_grant;
         if (w_grant) begin
            r_resp_id <= w_gnt_idx;
            r_rr_ptr  <= w_rr_next;
         end
         case (r_state)
            ST_CLEAR: begin
               // flush_req is deliberately ignored here: the sweep never restarts.
               if (r_clr_cnt == AW'(SETS_NUM - 1)) begin
                  r_clr_cnt   <= '0;
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (flush_req) begin
                  r_state     <= ST_CLEAR;
                  r_init_done <= 1'b0;
               end
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

endmodule
